// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// One double-dabble iteration per clock, valid/ready on both sides.
//
// Parameters:
//   BIN_W   binary input width (>= 4)
//   DIGITS  number of BCD output digits (>= 1)
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake, bin_in sampled at accept edge
//   out_valid/out_ready output handshake, result held under backpressure
//   bcd_out           digit i at [4i+3:4i], saturated to all 9s on overflow
//   overflow          input value exceeds 10^DIGITS-1
//   blank             per-digit leading-zero flags
// Build option:
//   BCD_BLANK_EN      when defined, drives leading-zero blank flags;
//                     otherwise blank is tied to 0.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [BIN_W-1:0] bin_q;
    logic [BW-1:0]    bcd_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bcd_o_q;
    logic             ovf_o_q;

    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_d;
    logic [BIN_W-1:0] bin_d;
    logic             ovf_d;
    logic [BW-1:0]    res_d;

    // One iteration: add 3 to each digit >= 5 (no inter-digit carry),
    // then shift {bcd, bin} left. The bit leaving the top digit means
    // the value no longer fits in DIGITS digits.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
        end
        bcd_d = {bcd_adj[BW-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_q | bcd_adj[BW-1];
        res_d = ovf_d ? {DIGITS{4'h9}} : bcd_d;
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_d;
    logic              zero_above;

    // Digit i is blanked when it and every higher digit are zero.
    // The ones digit always shows, and a saturated result never blanks.
    always_comb begin
        blank_d    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (res_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above & ~ovf_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            bcd_o_q <= '0;
            ovf_o_q <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bin_q   <= bin_in;
                        bcd_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Final iteration: capture the result straight into
                    // the output registers so out_valid and data align.
                    if (cnt_q == LAST) begin
                        bcd_o_q <= res_d;
                        ovf_o_q <= ovf_d;
`ifdef BCD_BLANK_EN
                        blank_q <= blank_d;
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_o_q;
    assign overflow  = ovf_o_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq.
// Two instances: 12-bit/4-digit and 12-bit/3-digit (saturating range).
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] bin_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] bcd_out;
    logic        overflow;
    logic [3:0]  blank;

    logic        iv3 = 1'b0;
    logic        ir3;
    logic [11:0] bi3 = '0;
    logic        ov3;
    logic        or3 = 1'b0;
    logic [11:0] bcd3;
    logic        of3;
    logic [2:0]  bl3;

    int vec = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .overflow  (overflow),
        .blank     (blank)
    );

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .bin_in    (bi3),
        .out_valid (ov3),
        .out_ready (or3),
        .bcd_out   (bcd3),
        .overflow  (of3),
        .blank     (bl3)
    );

    // Decimal reference: digits from division, saturation from range.
    function automatic void model(input int v, input int d,
                                  output logic [15:0] b,
                                  output logic o,
                                  output logic [3:0] bl);
        int lim;
        int pw;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        o  = (v > lim - 1);
        b  = '0;
        bl = '0;
        pw = 1;
        for (int i = 0; i < d; i++) begin
            b[4*i +: 4] = o ? 4'd9 : 4'((v / pw) % 10);
`ifdef BCD_BLANK_EN
            if (i >= 1) bl[i] = !o && (v < pw);
`endif
            pw = pw * 10;
        end
    endfunction

    // Called #1 after a rising edge with the 4-digit DUT idle.
    task automatic conv4(input int v, output int lat,
                         output logic [15:0] b, output logic o,
                         output logic [3:0] bl);
        in_valid = 1'b1;
        bin_in   = 12'(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        bin_in   = 12'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        b  = bcd_out;
        o  = overflow;
        bl = blank;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic conv3(input int v, output int lat,
                         output logic [11:0] b, output logic o,
                         output logic [2:0] bl);
        iv3 = 1'b1;
        bi3 = 12'(v);
        @(posedge clk); #1;
        iv3 = 1'b0;
        bi3 = 12'($urandom);
        lat = 0;
        while (!ov3 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        b  = bcd3;
        o  = of3;
        bl = bl3;
        or3 = 1'b1;
        @(posedge clk); #1;
        or3 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== 16'h0 ||
            overflow !== 1'b0 || blank !== 4'h0) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b bcd=%h ovf=%b blk=%b want 1 0 0000 0 0000",
                     in_ready, out_valid, bcd_out, overflow, blank);
        end
        vec++;
        if (ir3 !== 1'b1 || ov3 !== 1'b0 || bcd3 !== 12'h0 || of3 !== 1'b0) begin
            bad++;
            $display("FAIL reset3: rdy=%b vld=%b bcd=%h ovf=%b want 1 0 000 0",
                     ir3, ov3, bcd3, of3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_corners();
        int          vals[8] = '{4095, 0, 1, 9, 10, 100, 999, 1000};
        int          lat;
        logic [15:0] b, eb;
        logic        o, eo;
        logic [3:0]  bl, ebl;
        foreach (vals[k]) begin
            conv4(vals[k], lat, b, o, bl);
            model(vals[k], 4, eb, eo, ebl);
            vec++;
            if (lat !== 12) begin
                bad++;
                $display("FAIL latency v=%0d: got %0d want 12", vals[k], lat);
            end
            vec++;
            if (b !== eb || o !== eo || bl !== ebl) begin
                bad++;
                $display("FAIL corner v=%0d: bcd=%h ovf=%b blk=%b want %h %b %b",
                         vals[k], b, o, bl, eb, eo, ebl);
            end
        end
    endtask

    task automatic test_overflow();
        int          vals[6] = '{1000, 999, 4095, 0, 1001, 998};
        int          lat;
        logic [11:0] b;
        logic        o, eo;
        logic [2:0]  bl;
        logic [15:0] eb;
        logic [3:0]  ebl;
        foreach (vals[k]) begin
            conv3(vals[k], lat, b, o, bl);
            model(vals[k], 3, eb, eo, ebl);
            vec++;
            if (lat !== 12 || b !== eb[11:0] || o !== eo || bl !== ebl[2:0]) begin
                bad++;
                $display("FAIL ovf3 v=%0d: lat=%0d bcd=%h ovf=%b blk=%b want 12 %h %b %b",
                         vals[k], lat, b, o, bl, eb[11:0], eo, ebl[2:0]);
            end
        end
        for (int n = 0; n < 150; n++) begin
            int v;
            v = int'($urandom_range(0, 4095));
            conv3(v, lat, b, o, bl);
            model(v, 3, eb, eo, ebl);
            vec++;
            if (lat !== 12 || b !== eb[11:0] || o !== eo || bl !== ebl[2:0]) begin
                bad++;
                $display("FAIL rand3 v=%0d: lat=%0d bcd=%h ovf=%b blk=%b want 12 %h %b %b",
                         v, lat, b, o, bl, eb[11:0], eo, ebl[2:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        int          hold_bad;
        logic [15:0] b, eb;
        logic        o, eo;
        logic [3:0]  bl, ebl;
        in_valid = 1'b1;
        bin_in   = 12'd2748;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        model(2748, 4, eb, eo, ebl);
        vec++;
        if (lat !== 12) begin
            bad++;
            $display("FAIL bp_latency: got %0d want 12", lat);
        end
        in_valid = 1'b1;
        bin_in   = 12'd123;
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || bcd_out !== eb ||
                overflow !== eo || blank !== ebl)
                hold_bad++;
        end
        vec++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d unstable cycles, bcd=%h want %h",
                     hold_bad, bcd_out, eb);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        in_valid = 1'b0;
        conv4(321, lat, b, o, bl);
        model(321, 4, eb, eo, ebl);
        vec++;
        if (lat !== 12 || b !== eb || o !== eo || bl !== ebl) begin
            bad++;
            $display("FAIL bp_next: lat=%0d bcd=%h ovf=%b blk=%b want 12 %h %b %b",
                     lat, b, o, bl, eb, eo, ebl);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [15:0] b, eb;
        logic        o, eo;
        logic [3:0]  bl, ebl;
        in_valid = 1'b1;
        bin_in   = 12'd2748;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy: rdy=%b vld=%b want 0 0", in_ready, out_valid);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== 16'h0 ||
            overflow !== 1'b0 || blank !== 4'h0) begin
            bad++;
            $display("FAIL midreset: rdy=%b vld=%b bcd=%h ovf=%b blk=%b want 1 0 0000 0 0000",
                     in_ready, out_valid, bcd_out, overflow, blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        conv4(37, lat, b, o, bl);
        model(37, 4, eb, eo, ebl);
        vec++;
        if (lat !== 12 || b !== eb || o !== eo || bl !== ebl) begin
            bad++;
            $display("FAIL after_reset: lat=%0d bcd=%h ovf=%b blk=%b want 12 %h %b %b",
                     lat, b, o, bl, eb, eo, ebl);
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [15:0] b, eb;
        logic        o, eo;
        logic [3:0]  bl, ebl;
        for (int n = 0; n < 200; n++) begin
            int v;
            v = int'($urandom_range(0, 4095));
            conv4(v, lat, b, o, bl);
            model(v, 4, eb, eo, ebl);
            vec++;
            if (lat !== 12 || b !== eb || o !== eo || bl !== ebl) begin
                bad++;
                $display("FAIL rand v=%0d: lat=%0d bcd=%h ovf=%b blk=%b want 12 %h %b %b",
                         v, lat, b, o, bl, eb, eo, ebl);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [15:0] b, eb;
        logic        o, eo;
        logic [3:0]  bl, ebl;
        for (int v = 0; v < 4096; v++) begin
            conv4(v, lat, b, o, bl);
            model(v, 4, eb, eo, ebl);
            vec++;
            if (lat !== 12 || b !== eb || o !== eo || bl !== ebl) begin
                bad++;
                $display("FAIL sweep v=%0d: lat=%0d bcd=%h ovf=%b blk=%b want 12 %h %b %b",
                         v, lat, b, o, bl, eb, eo, ebl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
